mux4_rr_arbiter: RTL

Round-robin arbiter that shares one mux4_1 datapath between four requesters. It produces the 2-bit select S that drives mux4_1, plus a one-hot grant back to the requesters. A hold limit bounds how long one requester may keep the mux while others wait. Sits directly in front of mux4_1; S connects to the mux select and req[i] corresponds to mux input i (0=a, 1=b, 2=c, 3=d).

---
 rtl/mux4_rr_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared mux4_1 datapath.
// Grants are registered; a hold limit forces rotation only while others are waiting.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] S,
    output logic       busy
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       s_q, s_d;

    logic [3:0] others;
    logic [1:0] nxt;

    // First set bit of v, searching base, base+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (v[idx]) rr_pick = idx;
        end
    endfunction

    assign others = req & ~gnt_q;
    assign nxt    = s_q + 2'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    state_d = StGrant;
                    s_d     = rr_pick(req, ptr_q);
                    gnt_d   = 4'b0001 << rr_pick(req, ptr_q);
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (!req[s_q] || (others != 4'b0000 && cnt_q == CntMax)) begin
                    ptr_d = nxt;
                    cnt_d = '0;
                    if (others != 4'b0000) begin
                        s_d   = rr_pick(others, nxt);
                        gnt_d = 4'b0001 << rr_pick(others, nxt);
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
                end else if (cnt_q != CntMax) begin
                    // Saturates when uncontested so a late requester waits at most one cycle.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
        end
    end

    assign gnt  = gnt_q;
    assign S    = s_q;
    assign busy = |gnt_q;

endmodule
